// File: rtl/vacc_pkg.sv
// Shared types for the vector-accumulator readout path.
// Holds the address-width helper and the readout FSM encoding.
package vacc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO used as a skid buffer on stream outputs.
// Ports: clk, rst (async high), push/din, pop/dout (head), count (0..2).
module skid_fifo2
  import vacc_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         rp;
  logic         wp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rp     <= 1'b0;
      wp     <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) begin
        rp <= ~rp;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout = mem[rp];

endmodule

// File: rtl/vacc_bram_reader.sv
// Streams every accumulator BRAM word out on valid/ready, optionally
// clearing each location as it is read. Ports: start/busy/done control,
// bram_* read+clear-write port, m_data/m_valid/m_ready/m_last stream.
module vacc_bram_reader
  import vacc_pkg::*;
#(
  parameter int N_ADDR        = 256,
  parameter int DATA_WIDTH    = 16,
  parameter bit CLEAR_ON_READ = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        bram_ren,
  output logic [addr_w(N_ADDR)-1:0]   bram_radd,
  input  logic [DATA_WIDTH-1:0]       bram_rdata,
  output logic                        bram_wen,
  output logic [addr_w(N_ADDR)-1:0]   bram_wadd,
  output logic [DATA_WIDTH-1:0]       bram_win,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_last
);

  localparam int AW = addr_w(N_ADDR);

  state_t          state;
  state_t          state_nx;
  logic [AW-1:0]   addr;
  logic            inflight;
  logic            inflight_last;
  logic            done_q;
  logic [1:0]      count;
  logic [DATA_WIDTH:0] fifo_dout;
  logic            fifo_empty;
  logic            ren;
  logic            issue_last;
  logic            xfer;
  logic            push;
  logic            pop;

  assign fifo_empty = (count == 2'd0);
  assign issue_last = (addr == AW'(N_ADDR - 1));

  // Credit: never more words outstanding than the FIFO can absorb.
  assign ren = (state == S_READ) &&
               ((count + {1'b0, inflight}) < 2'd2);

  // Head of FIFO if it holds data, else bypass the word landing now.
  assign m_valid = !fifo_empty || inflight;
  assign m_data  = !fifo_empty ? fifo_dout[DATA_WIDTH-1:0] :
                   (inflight ? bram_rdata : '0);
  assign m_last  = !fifo_empty ? fifo_dout[DATA_WIDTH] :
                   (inflight && inflight_last);

  assign xfer = m_valid && m_ready;
  assign pop  = !fifo_empty && m_ready;
  // Arriving word is parked unless it leaves on the bypass this cycle.
  assign push = inflight && !(fifo_empty && m_ready);

  skid_fifo2 #(
    .W(DATA_WIDTH + 1)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  ({inflight_last, bram_rdata}),
    .pop  (pop),
    .dout (fifo_dout),
    .count(count)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_READ;
      S_READ:  if (ren && issue_last) state_nx = S_DRAIN;
      S_DRAIN: if (done_q) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      addr          <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state         <= state_nx;
      inflight      <= ren;
      inflight_last <= ren && issue_last;
      done_q        <= xfer && m_last;
      if (state == S_IDLE && start) begin
        addr <= '0;
      end else if (ren) begin
        addr <= addr + AW'(1);
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = done_q;
  assign bram_ren  = ren;
  assign bram_radd = addr;
  assign bram_wadd = addr;
  assign bram_wen  = CLEAR_ON_READ && ren;
  assign bram_win  = '0;

endmodule

// File: tb/tb_vacc_bram_reader.sv
// Scoreboard bench for vacc_bram_reader (N_ADDR=8).
// Instance a clears on read, instance b does not.
module tb_vacc_bram_reader;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int AW = 3;

  typedef struct packed {
    logic          l;
    logic [DW-1:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          rdy = 1'b0;
  logic          start_a = 1'b0, start_b = 1'b0;
  logic          busy_a, done_a, ren_a, wen_a, mv_a, ml_a;
  logic          busy_b, done_b, ren_b, wen_b, mv_b, ml_b;
  logic [AW-1:0] radd_a, wadd_a, radd_b, wadd_b;
  logic [DW-1:0] rdata_a, rdata_b, win_a, win_b, md_a, md_b;
  logic [DW-1:0] mem_a [N];
  logic [DW-1:0] mem_b [N];
  logic [DW-1:0] exp_a [N];
  logic [DW-1:0] exp_b [N];
  logic          pre_a = 1'b0, pre_b = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   rmode = 0;
  int   cyc = 0;
  exp_t qa[$];
  exp_t qb[$];
  int   words_a, words_b, dones_a, dones_b, rens_a;

  vacc_bram_reader #(.N_ADDR(N), .DATA_WIDTH(DW), .CLEAR_ON_READ(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .bram_ren(ren_a), .bram_radd(radd_a), .bram_rdata(rdata_a),
    .bram_wen(wen_a), .bram_wadd(wadd_a), .bram_win(win_a),
    .m_data(md_a), .m_valid(mv_a), .m_ready(rdy), .m_last(ml_a)
  );

  vacc_bram_reader #(.N_ADDR(N), .DATA_WIDTH(DW), .CLEAR_ON_READ(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .bram_ren(ren_b), .bram_radd(radd_b), .bram_rdata(rdata_b),
    .bram_wen(wen_b), .bram_wadd(wadd_b), .bram_win(win_b),
    .m_data(md_b), .m_valid(mv_b), .m_ready(rdy), .m_last(ml_b)
  );

  // Read-first BRAM models with a preload strobe.
  always @(posedge clk) begin
    if (pre_a) begin
      for (int i = 0; i < N; i++) mem_a[i] <= DW'(i + 100);
    end else begin
      if (ren_a) rdata_a <= mem_a[radd_a];
      if (wen_a) mem_a[wadd_a] <= win_a;
    end
  end

  always @(posedge clk) begin
    if (pre_b) begin
      for (int i = 0; i < N; i++) mem_b[i] <= DW'(i + 100);
    end else begin
      if (ren_b) rdata_b <= mem_b[radd_b];
      if (wen_b) mem_b[wadd_b] <= win_b;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       rdy = 1'b1;
      1:       rdy = (cyc % 3 == 0);
      default: rdy = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor a: scoreboard, stall stability, done-after-last.
  logic          st_a = 1'b0, px_a = 1'b0, pl_a = 1'b0;
  logic [DW-1:0] pd_a = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      st_a = 1'b0;
      px_a = 1'b0;
    end else begin
      if (st_a) chk("stable_a", 32'({mv_a, ml_a, md_a}), 32'({1'b1, pl_a, pd_a}));
      if (done_a) begin
        dones_a++;
        chk("done_after_last_a", 32'(px_a), 32'd1);
      end
      if (ren_a) rens_a++;
      if (mv_a && rdy) begin
        words_a++;
        if (qa.size() == 0) begin
          chk("extra_word_a", 32'(md_a), 32'hFFFF_FFFF);
        end else begin
          e = qa.pop_front();
          chk("word_a", 32'({ml_a, md_a}), 32'(e));
        end
      end
      px_a = mv_a && rdy && ml_a;
      st_a = mv_a && !rdy;
      pd_a = md_a;
      pl_a = ml_a;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done_b) dones_b++;
      if (mv_b && rdy) begin
        words_b++;
        if (qb.size() == 0) begin
          chk("extra_word_b", 32'(md_b), 32'hFFFF_FFFF);
        end else begin
          e = qb.pop_front();
          chk("word_b", 32'({ml_b, md_b}), 32'(e));
        end
      end
    end
  end

  task automatic preload(input bit b);
    @(posedge clk); #1;
    if (b) pre_b = 1'b1; else pre_a = 1'b1;
    @(posedge clk); #1;
    pre_a = 1'b0;
    pre_b = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (b) exp_b[i] = DW'(i + 100); else exp_a[i] = DW'(i + 100);
    end
  endtask

  task automatic push_exp(input bit b);
    for (int i = 0; i < N; i++) begin
      if (b) qb.push_back({(i == N - 1), exp_b[i]});
      else begin
        qa.push_back({(i == N - 1), exp_a[i]});
        exp_a[i] = '0;
      end
    end
  endtask

  task automatic pulse_start(input bit b);
    @(posedge clk); #1;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic clr_cnt();
    words_a = 0; words_b = 0; dones_a = 0; dones_b = 0; rens_a = 0;
  endtask

  task automatic wait_idle(input bit b, input int max);
    int n;
    n = 0;
    while ((b ? busy_b : busy_a) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(b ? "timeout_b" : "timeout_a", 32'(b ? busy_b : busy_a), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #2;
    chk("rst_outs", 32'({busy_a, done_a, ren_a, wen_a, mv_a, ml_a, radd_a}), 32'd0);
    chk("rst_data", 32'(md_a), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    clr_cnt();

    // 1: ready high, cycle-exact timing, memory cleared afterwards.
    rmode = 0;
    preload(1'b0);
    push_exp(1'b0);
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      if (j == 1) begin
        chk("k1_busy_ren", 32'({busy_a, ren_a, wen_a, mv_a}), 32'b1110);
        chk("k1_radd", 32'(radd_a), 32'd0);
        chk("k1_win", 32'(win_a), 32'd0);
      end
      if (j == 2) chk("k2_valid", 32'(mv_a), 32'd1);
      if (j == 9) chk("k9_last", 32'(ml_a), 32'd1);
      if (j == 10) chk("k10_done", 32'({done_a, busy_a}), 32'b11);
      if (j == 11) chk("k11_idle", 32'({done_a, busy_a}), 32'b00);
    end
    chk("t1_words", 32'(words_a), 32'd8);
    chk("t1_dones", 32'(dones_a), 32'd1);
    for (int i = 0; i < N; i++) chk("t1_cleared", 32'(mem_a[i]), 32'd0);

    // 2: ready at 1/3 duty.
    clr_cnt();
    rmode = 1;
    preload(1'b0);
    push_exp(1'b0);
    pulse_start(1'b0);
    wait_idle(1'b0, 200);
    chk("t2_words", 32'(words_a), 32'd8);
    chk("t2_queue", 32'(qa.size()), 32'd0);

    // 3: no clear, two back-to-back readouts.
    clr_cnt();
    rmode = 0;
    preload(1'b1);
    push_exp(1'b1);
    push_exp(1'b1);
    pulse_start(1'b1);
    wait_idle(1'b1, 50);
    pulse_start(1'b1);
    wait_idle(1'b1, 50);
    chk("t3_words", 32'(words_b), 32'd16);
    chk("t3_dones", 32'(dones_b), 32'd2);
    chk("t3_mem7", 32'(mem_b[7]), 32'd107);

    // 4: second start while busy is ignored.
    clr_cnt();
    preload(1'b0);
    push_exp(1'b0);
    pulse_start(1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_idle(1'b0, 50);
    repeat (4) @(negedge clk);
    chk("t4_words", 32'(words_a), 32'd8);
    chk("t4_dones", 32'(dones_a), 32'd1);
    chk("t4_busy", 32'(busy_a), 32'd0);

    // 5: reset mid-readout at cycle 5.
    clr_cnt();
    preload(1'b0);
    push_exp(1'b0);
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t5_rst_outs", 32'({busy_a, done_a, ren_a, wen_a, mv_a, ml_a, radd_a}), 32'd0);
    chk("t5_rst_data", 32'(md_a), 32'd0);
    qa.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) chk("t5_cleared", 32'(mem_a[i]), 32'd0);
    for (int i = 4; i < N; i++) chk("t5_kept", 32'(mem_a[i]), 32'(i + 100));
    for (int i = 0; i < N; i++) exp_a[i] = (i < 4) ? DW'(0) : DW'(i + 100);
    clr_cnt();
    push_exp(1'b0);
    pulse_start(1'b0);
    wait_idle(1'b0, 50);
    chk("t5_words", 32'(words_a), 32'd8);

    // 6: ready low for 20 cycles after start.
    clr_cnt();
    rmode = 2;
    preload(1'b0);
    push_exp(1'b0);
    pulse_start(1'b0);
    repeat (20) @(negedge clk);
    chk("t6_reads", 32'(rens_a), 32'd2);
    chk("t6_nowords", 32'(words_a), 32'd0);
    rmode = 0;
    wait_idle(1'b0, 60);
    chk("t6_words", 32'(words_a), 32'd8);
    chk("t6_dones", 32'(dones_a), 32'd1);
    chk("t6_queue", 32'(qa.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
